// File: rtl/intersection_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | intersection_pkg: lamp codes, phases and helpers for the          |
// | four-approach right-of-way scheduler.          Revision: 1.0      |
// +------------------------------------------------------------------+
package intersection_pkg;

    localparam int NUM_APPROACH = 4;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } lamp_e;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2
    } phase_e;

    function automatic logic [NUM_APPROACH-1:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/intersection_scheduler_rr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_next_approach: picks the first requesting approach after the   |
// | active one, wrapping modulo four.              Revision: 1.0      |
// +------------------------------------------------------------------+
module rr_next_approach
    import intersection_pkg::*;
(
    input  logic [NUM_APPROACH-1:0] others_i,
    input  logic [1:0]              active_i,
    output logic [1:0]              next_o,
    output logic                    valid_o
);

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        next_o  = active_i;
        valid_o = 1'b0;
        for (int k = NUM_APPROACH - 1; k >= 1; k--) begin
            if (others_i[active_i + 2'(k)]) begin
                next_o  = active_i + 2'(k);
                valid_o = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/intersection_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | intersection_scheduler: round-robin green/yellow/all-red sequencer |
// | for four approaches with emergency preemption. Revision: 1.0      |
// +------------------------------------------------------------------+
module intersection_scheduler
    import intersection_pkg::*;
#(
    parameter int MIN_GREEN   = 8,
    parameter int MAX_GREEN   = 20,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2,
    parameter int HOME        = 0
) (
    input  logic                    clock,
    input  logic                    clear_n,
    input  logic [NUM_APPROACH-1:0] req,
    input  logic                    preempt,
    input  logic [1:0]              preempt_dir,
    output logic [7:0]              sig,
    output logic [1:0]              active,
    output logic [1:0]              phase
);

    localparam int              CW       = $clog2(MAX_GREEN + 1);
    localparam logic [CW-1:0]   MIN_LAST = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0]   MAX_LAST = CW'(MAX_GREEN - 1);
    localparam logic [CW-1:0]   Y_LAST   = CW'(YELLOW_TIME - 1);
    localparam logic [CW-1:0]   A_LAST   = CW'(ALLRED_TIME - 1);
    localparam logic [1:0]      HOME_IDX = 2'(HOME);
    localparam logic [7:0]      SIG_HOME = 8'h02 << (2 * HOME);

    phase_e                  phase_q, phase_d;
    logic [1:0]              active_q, active_d;
    logic [1:0]              next_q, next_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_APPROACH-1:0] pending_q, pending_d;
    logic [7:0]              sig_q, sig_d;

    logic [NUM_APPROACH-1:0] others;
    logic [1:0]              rr_next;
    logic                    rr_valid;
    logic                    exit_green;
    logic [1:0]              exit_target;
    logic [1:0]              clear_target;
    lamp_e                   lamp;

    assign others = pending_q & ~onehot(active_q);

    rr_next_approach u_rr (
        .others_i (others),
        .active_i (active_q),
        .next_o   (rr_next),
        .valid_o  (rr_valid)
    );

    // Green exit decision; preemption overrides both minimum and maximum green.
    always_comb begin
        exit_green  = 1'b0;
        exit_target = active_q;
        if (preempt) begin
            if (preempt_dir != active_q) begin
                exit_green  = 1'b1;
                exit_target = preempt_dir;
            end
        end else if (cnt_q >= MIN_LAST) begin
            if (rr_valid && (!req[active_q] || cnt_q == MAX_LAST)) begin
                exit_green  = 1'b1;
                exit_target = rr_next;
            end else if (!rr_valid && active_q != HOME_IDX && !req[active_q]) begin
                exit_green  = 1'b1;
                exit_target = HOME_IDX;
            end
        end
    end

    assign clear_target = preempt ? preempt_dir : next_q;

    always_comb begin
        phase_d  = phase_q;
        active_d = active_q;
        next_d   = next_q;
        cnt_d    = cnt_q;
        case (phase_q)
            PH_GREEN: begin
                if (exit_green) begin
                    phase_d = PH_YELLOW;
                    next_d  = exit_target;
                    cnt_d   = '0;
                end else if (cnt_q != MAX_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PH_YELLOW: begin
                next_d = clear_target;
                if (cnt_q == Y_LAST) begin
                    phase_d = PH_ALLRED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PH_ALLRED: begin
                next_d = clear_target;
                if (cnt_q == A_LAST) begin
                    phase_d  = PH_GREEN;
                    active_d = clear_target;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                phase_d = PH_GREEN;
                cnt_d   = '0;
            end
        endcase
    end

    // The approach holding green never keeps a latched request of its own.
    always_comb begin
        pending_d = pending_q | req;
        if (phase_d == PH_GREEN) begin
            pending_d = pending_d & ~onehot(active_d);
        end
    end

    always_comb begin
        case (phase_d)
            PH_GREEN:  lamp = GREEN;
            PH_YELLOW: lamp = YELLOW;
            default:   lamp = RED;
        endcase
        sig_d = '0;
        for (int i = 0; i < NUM_APPROACH; i++) begin
            sig_d[2*i +: 2] = (2'(i) == active_d) ? lamp : RED;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            phase_q   <= PH_GREEN;
            active_q  <= HOME_IDX;
            next_q    <= HOME_IDX;
            cnt_q     <= '0;
            pending_q <= '0;
            sig_q     <= SIG_HOME;
        end else begin
            phase_q   <= phase_d;
            active_q  <= active_d;
            next_q    <= next_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            sig_q     <= sig_d;
        end
    end

    assign sig    = sig_q;
    assign active = active_q;
    assign phase  = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_intersection_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_intersection_scheduler: directed scenarios plus random traffic |
// | checked against a behavioural model.           Revision: 1.0      |
// +------------------------------------------------------------------+
module tb_intersection_scheduler;

    localparam int MIN_G = 4;
    localparam int MAX_G = 10;
    localparam int YT    = 2;
    localparam int AR    = 1;
    localparam int HOME  = 0;

    logic       clock       = 1'b0;
    logic       clear_n     = 1'b0;
    logic [3:0] req         = 4'b0;
    logic       preempt     = 1'b0;
    logic [1:0] preempt_dir = 2'd0;
    logic [7:0] sig;
    logic [1:0] active;
    logic [1:0] phase;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    intersection_scheduler #(
        .MIN_GREEN   (MIN_G),
        .MAX_GREEN   (MAX_G),
        .YELLOW_TIME (YT),
        .ALLRED_TIME (AR),
        .HOME        (HOME)
    ) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .req         (req),
        .preempt     (preempt),
        .preempt_dir (preempt_dir),
        .sig         (sig),
        .active      (active),
        .phase       (phase)
    );

    always #5 clock = ~clock;

    // Model: phase 0/1/2, elapsed cycles in the phase, target of the next green.
    int       m_phase;
    int       m_active;
    int       m_target;
    int       m_elapsed;
    bit [3:0] m_pend;

    function automatic logic [7:0] model_sig();
        int code;
        if (m_phase == 2) return 8'h00;
        code = (m_phase == 0) ? 2 : 1;
        return 8'(code << (2 * m_active));
    endfunction

    task automatic model_step(input bit [3:0] rq, input bit pre, input int dir);
        int  found;
        bit  leave;
        int  tgt;
        leave = 1'b0;
        tgt   = m_active;
        if (m_phase == 0) begin
            if (pre) begin
                if (dir != m_active) begin
                    leave = 1'b1;
                    tgt   = dir;
                end
            end else if (m_elapsed >= MIN_G - 1) begin
                found = -1;
                for (int k = 1; k < 4; k++)
                    if (found < 0 && m_pend[(m_active + k) % 4]) found = (m_active + k) % 4;
                if (found >= 0 && (!rq[m_active] || m_elapsed >= MAX_G - 1)) begin
                    leave = 1'b1;
                    tgt   = found;
                end else if (found < 0 && m_active != HOME && !rq[m_active]) begin
                    leave = 1'b1;
                    tgt   = HOME;
                end
            end
            if (leave) begin
                m_phase   = 1;
                m_target  = tgt;
                m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
        end else begin
            if (pre) m_target = dir;
            m_elapsed++;
            if (m_phase == 1 && m_elapsed == YT) begin
                m_phase   = 2;
                m_elapsed = 0;
            end else if (m_phase == 2 && m_elapsed == AR) begin
                m_phase   = 0;
                m_active  = m_target;
                m_elapsed = 0;
            end
        end
        m_pend = m_pend | rq;
        if (m_phase == 0) m_pend[m_active] = 1'b0;
    endtask

    always @(posedge clock) begin
        if (!clear_n) begin
            m_phase   = 0;
            m_active  = HOME;
            m_target  = HOME;
            m_elapsed = 0;
            m_pend    = 4'b0;
        end else begin
            model_step(req, preempt, int'(preempt_dir));
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            check("model_sig", sig, model_sig());
            check("model_active", {6'b0, active}, 8'(m_active));
            check("model_phase", {6'b0, phase}, 8'(m_phase));
        end
    end

    task automatic do_reset();
        @(negedge clock);
        clear_n = 1'b0;
        req     = 4'b0;
        preempt = 1'b0;
        @(negedge clock);
        clear_n = 1'b1;
        cmp_en  = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int  code;
        int  last;
        int  ngrant;
        bit  seen;

        // Idle: home rests green.
        do_reset();
        check("reset_sig", sig, 8'h02);
        check("reset_phase", {6'b0, phase}, 8'h00);
        step(50);
        check("idle_sig", sig, 8'h02);
        check("idle_phase", {6'b0, phase}, 8'h00);

        // Single request on approach 2, then return home.
        do_reset();
        step(1);
        req = 4'b0100;
        step(1);
        req = 4'b0000;
        step(1);
        check("min_green_hold", sig, 8'h02);
        step(1);
        check("yellow0_sig", sig, 8'h01);
        check("yellow0_model", model_sig(), 8'h01);
        step(2);
        check("allred_sig", sig, 8'h00);
        check("allred_phase", {6'b0, phase}, 8'h02);
        step(1);
        check("green2_sig", sig, 8'h20);
        check("green2_active", {6'b0, active}, 8'h02);
        check("green2_model", model_sig(), 8'h20);
        step(3);
        check("green2_hold", sig, 8'h20);
        step(1);
        check("yellow2_sig", sig, 8'h10);
        step(3);
        check("home_again_sig", sig, 8'h02);
        check("home_again_active", {6'b0, active}, 8'h00);

        // Max-out with req[0] held.
        do_reset();
        req = 4'b0011;
        step(1);
        req = 4'b0001;
        step(8);
        check("maxout_hold", sig, 8'h02);
        step(1);
        check("maxout_yellow", sig, 8'h01);
        step(3);
        check("maxout_green1", sig, 8'h08);
        check("maxout_active1", {6'b0, active}, 8'h01);
        req = 4'b0000;
        step(40);

        // Round-robin order 1,2,3 then home.
        do_reset();
        req = 4'b1110;
        step(1);
        req = 4'b0000;
        code   = 0;
        last   = 0;
        ngrant = 0;
        for (int c = 0; c < 100 && ngrant < 4; c++) begin
            step(1);
            if (phase == 2'd0 && int'(active) != last) begin
                last   = int'(active);
                code   = code * 10 + last;
                ngrant++;
            end
        end
        check("rr_order", 8'(code % 256), 8'(1230 % 256));
        check("rr_grants", 8'(ngrant), 8'd4);

        // Preemption to approach 3 at gcnt=1, held against a pending request.
        do_reset();
        step(1);
        preempt     = 1'b1;
        preempt_dir = 2'd3;
        step(1);
        check("preempt_yellow", sig, 8'h01);
        step(3);
        check("preempt_green3", sig, 8'h80);
        req = 4'b0010;
        step(1);
        req = 4'b0000;
        step(20);
        check("preempt_hold", sig, 8'h80);
        preempt = 1'b0;
        step(1);
        check("preempt_release", sig, 8'h40);
        step(30);

        // Reset during all-red discards the latched request.
        do_reset();
        step(1);
        req = 4'b0100;
        step(1);
        req  = 4'b0000;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            step(1);
            if (phase == 2'd2) seen = 1'b1;
        end
        check("reach_allred", {7'b0, seen}, 8'h01);
        clear_n = 1'b0;
        step(1);
        clear_n = 1'b1;
        check("abort_sig", sig, 8'h02);
        check("abort_phase", {6'b0, phase}, 8'h00);
        step(12);
        check("abort_pending_clear", sig, 8'h02);

        // Random traffic with preemption bursts and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) req[i] = ($urandom_range(0, 99) < 8);
            if (preempt) begin
                if ($urandom_range(0, 99) < 5) preempt = 1'b0;
                else if ($urandom_range(0, 99) < 3) preempt_dir = 2'($urandom_range(0, 3));
            end else if ($urandom_range(0, 99) < 1) begin
                preempt     = 1'b1;
                preempt_dir = 2'($urandom_range(0, 3));
            end
            clear_n = ($urandom_range(0, 999) >= 2);
            step(1);
        end
        clear_n = 1'b1;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
